// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment vectors are active-high with bit0 = a through bit6 = g.
package seg7_pkg;

   // Bit positions of each segment inside a 7-bit segment vector
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   // Middle bar only; marks a non-BCD nibble on the display
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Update channel into the scan driver: valid/ready handshake carrying a
// packed BCD word (nibble i = digit i, digit 0 rightmost) and dp bits.
interface seg7_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      up_valid;
   logic                      up_ready;
   logic [4*NUM_DIGITS-1:0]   up_digits;
   logic [NUM_DIGITS-1:0]     up_dp;

   modport master (
      output up_valid,
      output up_digits,
      output up_dp,
      input  up_ready
   );

   modport slave (
      input  up_valid,
      input  up_digits,
      input  up_dp,
      output up_ready
   );
endinterface

// File: rtl/seg7_scan_mux_bcd_decode.sv
// Combinational BCD to seven-segment decoder. Nibbles above 9 produce a
// dash so that a corrupted count is visibly flagged instead of blanked.
module seg7_bcd_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Map one BCD nibble onto its segment pattern
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-cathode seven-segment driver.
// Accepts BCD words over a valid/ready channel, commits them only at frame
// boundaries (tear-free), and scans one digit per slot with a blanking gap
// at the start of each slot to suppress ghosting.
// Optional build macro SEG7_SCAN_LZB_EN enables leading-zero blanking.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 250,
   parameter int BLANK_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   seg7_scan_mux_if.slave        up,
   output logic [6:0]            segments,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  frame_tick
);

   localparam int SLOT_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] EN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   logic [SLOT_W-1:0]         slot_cnt_r;
   logic [IDX_W-1:0]          dig_idx_r;
   logic                      pend_r;
   logic [4*NUM_DIGITS-1:0]   pend_digits_r;
   logic [NUM_DIGITS-1:0]     pend_dp_r;
   logic [4*NUM_DIGITS-1:0]   disp_digits_r;
   logic [NUM_DIGITS-1:0]     disp_dp_r;

   logic                      boundary_s;
   logic                      xfer_s;
   logic                      commit_s;
   logic                      in_blank_s;
   logic [3:0]                nib_s;
   logic                      dp_sel_s;
   logic                      hide_s;
   logic [6:0]                dec_seg_s;

`ifdef SEG7_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0]     blank_mask_r;

   // Walk down from the top digit; a digit stays hidden while it and every
   // digit above it are zero without dp. Digit 0 is never hidden.
   function automatic logic [NUM_DIGITS-1:0] lzb_mask(
      input logic [4*NUM_DIGITS-1:0] digits,
      input logic [NUM_DIGITS-1:0]   dps
   );
      logic [NUM_DIGITS-1:0] mask;
      logic                  leading;
      mask    = '0;
      leading = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         leading = leading & (digits[4*i +: 4] == 4'd0) & ~dps[i];
         mask[i] = leading;
      end
      return mask;
   endfunction
`endif

   assign up.up_ready = ~pend_r;

   // Frame boundary detection and handshake qualifiers
   always_comb begin
      boundary_s = (slot_cnt_r == SLOT_LAST) && (dig_idx_r == IDX_LAST);
      xfer_s     = up.up_valid && !pend_r;
      commit_s   = boundary_s && pend_r;
      in_blank_s = (slot_cnt_r < BLANK_END);
   end

   // Select the nibble, dp bit and hide flag of the digit being scanned
   always_comb begin
      nib_s    = 4'd0;
      dp_sel_s = 1'b0;
      hide_s   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib_s    = (dig_idx_r == IDX_W'(i)) ? disp_digits_r[4*i +: 4] : nib_s;
         dp_sel_s = (dig_idx_r == IDX_W'(i)) ? disp_dp_r[i] : dp_sel_s;
`ifdef SEG7_SCAN_LZB_EN
         hide_s   = (dig_idx_r == IDX_W'(i)) ? blank_mask_r[i] : hide_s;
`else
         hide_s   = 1'b0;
`endif
      end
   end

   seg7_bcd_decode u_decode (
      .bcd (nib_s),
      .seg (dec_seg_s)
   );

   // Slot and digit scan counters
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt_r <= '0;
         dig_idx_r  <= '0;
      end else if (slot_cnt_r == SLOT_LAST) begin
         slot_cnt_r <= '0;
         dig_idx_r  <= (dig_idx_r == IDX_LAST) ? '0 : dig_idx_r + IDX_W'(1);
      end else begin
         slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
      end
   end

   // Pending capture on handshake, commit to display at frame boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_r        <= 1'b0;
         pend_digits_r <= '0;
         pend_dp_r     <= '0;
         disp_digits_r <= '0;
         disp_dp_r     <= '0;
`ifdef SEG7_SCAN_LZB_EN
         blank_mask_r  <= lzb_mask('0, '0);
`endif
      end else if (commit_s) begin
         pend_r        <= 1'b0;
         disp_digits_r <= pend_digits_r;
         disp_dp_r     <= pend_dp_r;
`ifdef SEG7_SCAN_LZB_EN
         blank_mask_r  <= lzb_mask(pend_digits_r, pend_dp_r);
`endif
      end else if (xfer_s) begin
         pend_r        <= 1'b1;
         pend_digits_r <= up.up_digits;
         pend_dp_r     <= up.up_dp;
      end else begin
         pend_r        <= pend_r;
      end
   end

   // Registered display outputs, dark during the blanking gap
   always_ff @(posedge clk) begin
      if (reset) begin
         segments   <= SEG_BLANK;
         dp         <= 1'b0;
         digit_en   <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= boundary_s;
         if (in_blank_s || hide_s) begin
            segments <= SEG_BLANK;
            dp       <= 1'b0;
            digit_en <= '0;
         end else begin
            segments <= dec_seg_s;
            dp       <= dp_sel_s;
            digit_en <= EN_ONE << dig_idx_r;
         end
      end
   end

endmodule
